cylon_sequencer: RTL and testbench
==================================

# cylon_sequencer

Step-sequencing controller for the cylon LED bar. It consumes the one-cycle `pulse` strobe from `pulse_generator` and divides it by a run-time speed setting. It walks a single lit LED back and forth across the bar, dwelling at each end. On disable it parks the bar cleanly at LED 0.

## Interface
- `N_LEDS`, 8, number of LEDs in the bar; legal range 2..32.
- `END_HOLD`, 1, extra step periods the lit LED dwells at each end; legal range 0..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pulse`  in  1  one-cycle timing strobe from `pulse_generator`.
- `enable`  in  1  level; 1 = run scanner, 0 = park and stop.
- `speed`  in  4  pulses per step minus one; a step occurs every `speed+1` pulses.
- `led`  out  N_LEDS  one-hot lit position, or all-zero when idle.
- `dir`  out  1  0 = moving up (toward MSB), 1 = moving down.
- `at_end`  out  1  high while the lit LED is dwelling at bit 0 or bit N_LEDS-1.
- `step`  out  1  one-cycle strobe, high in the cycle `led` takes a new step value.

## Operation
- State register values: IDLE, UP, DOWN, PARK.
- Internal registers:
  - `pos` (clog2(N_LEDS) bits).
  - Pulse counter `pcnt` (4 bits).
  - Hold counter `hcnt` (4 bits).
- Step event:
  - A step event occurs when `pulse`=1 and `pcnt >= speed`; `pcnt` then clears to 0.
  - Otherwise `pulse`=1 increments `pcnt`.
  - The compare uses `>=` so that lowering `speed` mid-count steps on the next pulse.
  - `pcnt` is held at 0 in IDLE.
- IDLE:
  - `led`=0.
  - `enable`=1 → UP with `pos`=0, `hcnt`=0, `pcnt`=0; `led`=1 on the next edge.
- UP, step event:
  - If `pos` < N_LEDS-1, `pos`+1.
  - If `pos` = N_LEDS-1 and `hcnt` < END_HOLD, `hcnt`+1.
  - Otherwise `hcnt`=0, `pos`−1, state DOWN.
- DOWN: mirror image of UP.
  - `pos`−1 until `pos`=0.
  - Dwell at `pos`=0 for END_HOLD steps.
  - Then `pos`+1, state UP.
- `enable`=0 in UP or DOWN → PARK on the next edge; `pos` and `pcnt` are retained and `hcnt` clears.
- PARK, step event:
  - If `pos` > 0, `pos`−1.
  - If `pos` = 0, state IDLE and `led`=0.
  - An entry with `pos`=0 still waits for one step before reaching IDLE.
- `enable`=1 in PARK → DOWN on the next edge, with `pos` and `pcnt` retained.
- Simultaneous `enable` change and step event: the state transition takes priority and the step event is discarded.
- `led` = one-hot of `pos` in UP, DOWN and PARK; `led` = 0 in IDLE.
- `dir` = 1 in DOWN and PARK, 0 otherwise.
- `at_end` = 1 when in UP or DOWN and `pos` is 0 or N_LEDS-1.

## Timing
- Reset values: state IDLE, `pos`=0, `pcnt`=0, `hcnt`=0, `led`=0, `dir`=0, `at_end`=0, `step`=0.
- `rst` mid-operation returns all of the above on the next edge regardless of `enable` or `pulse`.
- All outputs are registered.
- A qualifying `pulse` in cycle n produces the new `led` and `step`=1 in cycle n+1.
- The IDLE→UP transition also asserts `step`=1 with `led`=1.
- The PARK→IDLE transition asserts `step`=1 with `led`=0.
- A full period with N_LEDS=8 and END_HOLD=1 is 2·(7+1) = 16 step events.
- `pulse` arriving on consecutive cycles is legal; each one counts.

## Test plan
- Reset and start:
  - Stimulus: N_LEDS=8, END_HOLD=1, `speed`=0, `pulse` every 4 cycles, `rst` 3 cycles, then `enable`=1.
  - Required: `led`=0x01 one cycle later; then 0x02, 0x04 … 0x80 on successive pulses.
  - Required at top: 0x80 held for 2 steps with `at_end`=1, then 0x40 with `dir`=1.
- Speed divide:
  - Stimulus: `speed`=3.
  - Required: `led` changes on every 4th pulse only; `step` is high exactly one cycle per change.
  - Stimulus: change `speed` to 0 when `pcnt`=2.
  - Required: step on the next pulse.
- Park:
  - Stimulus: drop `enable` at `led`=0x10 while moving up.
  - Required: `dir`=1 next cycle; `led` steps 0x08, 0x04, 0x02, 0x01, then 0x00 and IDLE.
- Resume from park:
  - Stimulus: reassert `enable` while parking at 0x04.
  - Required: state DOWN; scan continues to 0x01, dwells 2 steps, then rises.
- Reset mid-scan and END_HOLD=0:
  - Stimulus: `rst` pulsed at `led`=0x20.
  - Required: all outputs zero next cycle, and no motion until `enable`.
  - Stimulus: build with END_HOLD=0.
  - Required: 0x80 is followed immediately by 0x40, with no dwell.

Source files
------------

// File: rtl/cylon_sequencer.sv
// cylon_sequencer
//
// Sweeps a single lit LED back and forth across an LED bar. Each step is
// taken after speed+1 timing pulses, and the lit LED dwells for END_HOLD
// extra steps at each end. When enable drops, the bar walks back down to
// LED 0, then goes dark.
//
// Ports
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   pulse   one-cycle timing strobe from pulse_generator
//   enable  1 = run the scanner, 0 = park at LED 0 and stop
//   speed   pulses per step minus one
//   led     one-hot lit position, all-zero when idle
//   dir     0 = moving toward the MSB, 1 = moving toward the LSB
//   at_end  lit LED is at bit 0 or bit N_LEDS-1 while scanning
//   step    one-cycle strobe in the cycle led takes a new step value
//
// State table
//   IDLE | bar dark, pulse counter held at zero
//   UP   | lit LED walking toward the MSB, dwelling at the top
//   DOWN | lit LED walking toward the LSB, dwelling at the bottom
//   PARK | enable dropped; walking down to LED 0, then going dark
module cylon_sequencer #(
    parameter int N_LEDS   = 8,
    parameter int END_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse,
    input  logic              enable,
    input  logic [3:0]        speed,
    output logic [N_LEDS-1:0] led,
    output logic              dir,
    output logic              at_end,
    output logic              step
);

    localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(N_LEDS - 1);
    localparam logic [3:0]    HOLD    = 4'(END_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        PARK = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] pos;
    logic [3:0]    pcnt;
    logic [3:0]    hcnt;
    logic          step_evt;

    // The >= compare means that lowering speed mid-count steps on the next pulse
    // instead of wrapping the counter.
    assign step_evt = pulse && (pcnt >= speed);

    function automatic logic [N_LEDS-1:0] onehot(input logic [PW-1:0] p);
        return N_LEDS'(1) << p;
    endfunction

    function automatic logic is_end(input logic [PW-1:0] p);
        return (p == '0) || (p == POS_MAX);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pos    <= '0;
            pcnt   <= '0;
            hcnt   <= '0;
            led    <= '0;
            dir    <= 1'b0;
            at_end <= 1'b0;
            step   <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                IDLE: begin
                    pcnt <= '0;
                    if (enable) begin
                        state  <= UP;
                        pos    <= '0;
                        hcnt   <= '0;
                        led    <= onehot('0);
                        dir    <= 1'b0;
                        at_end <= 1'b1;
                        step   <= 1'b1;
                    end else begin
                        led    <= '0;
                        dir    <= 1'b0;
                        at_end <= 1'b0;
                    end
                end

                UP: begin
                    // A change of enable wins over a simultaneous step event.
                    if (!enable) begin
                        state  <= PARK;
                        hcnt   <= '0;
                        dir    <= 1'b1;
                        at_end <= 1'b0;
                    end else if (step_evt) begin
                        pcnt <= '0;
                        step <= 1'b1;
                        if (pos != POS_MAX) begin
                            pos    <= pos + 1'b1;
                            led    <= onehot(pos + 1'b1);
                            at_end <= is_end(pos + 1'b1);
                        end else if (hcnt < HOLD) begin
                            hcnt <= hcnt + 1'b1;
                        end else begin
                            hcnt   <= '0;
                            pos    <= pos - 1'b1;
                            state  <= DOWN;
                            led    <= onehot(pos - 1'b1);
                            dir    <= 1'b1;
                            at_end <= is_end(pos - 1'b1);
                        end
                    end else if (pulse) begin
                        pcnt <= pcnt + 1'b1;
                    end
                end

                DOWN: begin
                    if (!enable) begin
                        state  <= PARK;
                        hcnt   <= '0;
                        dir    <= 1'b1;
                        at_end <= 1'b0;
                    end else if (step_evt) begin
                        pcnt <= '0;
                        step <= 1'b1;
                        if (pos != '0) begin
                            pos    <= pos - 1'b1;
                            led    <= onehot(pos - 1'b1);
                            at_end <= is_end(pos - 1'b1);
                        end else if (hcnt < HOLD) begin
                            hcnt <= hcnt + 1'b1;
                        end else begin
                            hcnt   <= '0;
                            pos    <= pos + 1'b1;
                            state  <= UP;
                            led    <= onehot(pos + 1'b1);
                            dir    <= 1'b0;
                            at_end <= is_end(pos + 1'b1);
                        end
                    end else if (pulse) begin
                        pcnt <= pcnt + 1'b1;
                    end
                end

                PARK: begin
                    if (enable) begin
                        state  <= DOWN;
                        dir    <= 1'b1;
                        at_end <= is_end(pos);
                    end else if (step_evt) begin
                        pcnt <= '0;
                        step <= 1'b1;
                        // Parking at LED 0 still takes one step to go dark.
                        if (pos != '0) begin
                            pos <= pos - 1'b1;
                            led <= onehot(pos - 1'b1);
                        end else begin
                            state <= IDLE;
                            led   <= '0;
                            dir   <= 1'b0;
                        end
                    end else if (pulse) begin
                        pcnt <= pcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cylon_sequencer.sv
module tb_cylon_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic       enable = 1'b0;
    logic       enable0 = 1'b0;
    logic [3:0] speed = 4'd0;

    logic [7:0] led, led0;
    logic       dir, dir0, at_end, at_end0, step, step0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] led;
        logic       dir;
        logic       at_end;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    exp_t e, e0;

    always #5 clk = ~clk;

    cylon_sequencer #(.N_LEDS(8), .END_HOLD(1)) dut (
        .clk(clk), .rst(rst), .pulse(pulse), .enable(enable), .speed(speed),
        .led(led), .dir(dir), .at_end(at_end), .step(step)
    );

    cylon_sequencer #(.N_LEDS(8), .END_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .pulse(pulse), .enable(enable0), .speed(speed),
        .led(led0), .dir(dir0), .at_end(at_end0), .step(step0)
    );

    // Scoreboard monitors: every step strobe must match the next queued entry.
    always @(negedge clk) begin
        if (step) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL step_unexpected hold1: got led=%h dir=%b at_end=%b, want no step",
                         led, dir, at_end);
            end else begin
                e = q.pop_front();
                if (led !== e.led || dir !== e.dir || at_end !== e.at_end) begin
                    bad++;
                    $display("FAIL %s hold1: got led=%h dir=%b at_end=%b, want led=%h dir=%b at_end=%b",
                             e.tag, led, dir, at_end, e.led, e.dir, e.at_end);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (step0) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL step_unexpected hold0: got led=%h dir=%b at_end=%b, want no step",
                         led0, dir0, at_end0);
            end else begin
                e0 = q0.pop_front();
                if (led0 !== e0.led || dir0 !== e0.dir || at_end0 !== e0.at_end) begin
                    bad++;
                    $display("FAIL %s hold0: got led=%h dir=%b at_end=%b, want led=%h dir=%b at_end=%b",
                             e0.tag, led0, dir0, at_end0, e0.led, e0.dir, e0.at_end);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] l, input logic d, input logic a,
                        input string tag);
        exp_t x;
        x.led = l;
        x.dir = d;
        x.at_end = a;
        x.tag = tag;
        if (sel == 0) q.push_back(x);
        else q0.push_back(x);
    endtask

    task automatic do_pulse(input int gap);
        repeat (gap) tick();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
    endtask

    task automatic pstep(input logic [7:0] l, input logic d, input logic a, input string tag);
        push(0, l, d, a, tag);
        do_pulse(3);
    endtask

    task automatic pnone(input int n);
        repeat (n) do_pulse(3);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (q.size() != 0 || q0.size() != 0); i++) tick();
        tick();
        check({name, "_pending"}, 32'(q.size() + q0.size()), 32'd0);
    endtask

    initial begin
        // Reset and start
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_led", 32'(led), 32'h00);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_at_end", 32'(at_end), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_led_hold0", 32'(led0), 32'h00);

        push(0, 8'h01, 1'b0, 1'b1, "start");
        enable = 1'b1;
        tick();
        check("start_led", 32'(led), 32'h01);
        pstep(8'h02, 1'b0, 1'b0, "up_02");
        pstep(8'h04, 1'b0, 1'b0, "up_04");
        pstep(8'h08, 1'b0, 1'b0, "up_08");
        pstep(8'h10, 1'b0, 1'b0, "up_10");
        pstep(8'h20, 1'b0, 1'b0, "up_20");
        pstep(8'h40, 1'b0, 1'b0, "up_40");
        pstep(8'h80, 1'b0, 1'b1, "top_arrive");
        pstep(8'h80, 1'b0, 1'b1, "top_dwell");
        pstep(8'h40, 1'b1, 1'b0, "down_40");
        pstep(8'h20, 1'b1, 1'b0, "down_20");
        pstep(8'h10, 1'b1, 1'b0, "down_10");
        pstep(8'h08, 1'b1, 1'b0, "down_08");
        pstep(8'h04, 1'b1, 1'b0, "down_04");
        pstep(8'h02, 1'b1, 1'b0, "down_02");
        pstep(8'h01, 1'b1, 1'b1, "bottom_arrive");
        pstep(8'h01, 1'b1, 1'b1, "bottom_dwell");
        pstep(8'h02, 1'b0, 1'b0, "rise_02");
        pstep(8'h04, 1'b0, 1'b0, "rise_04");
        pstep(8'h08, 1'b0, 1'b0, "rise_08");
        drain("scan");

        // Speed divide by four
        speed = 4'd3;
        pnone(3);
        check("div_hold_led", 32'(led), 32'h08);
        pstep(8'h10, 1'b0, 1'b0, "div_10");
        pnone(3);
        check("div_hold_led2", 32'(led), 32'h10);
        pstep(8'h20, 1'b0, 1'b0, "div_20");
        drain("divide");

        // Reset mid-scan with enable and pulse both high
        rst = 1'b1;
        pulse = 1'b1;
        tick();
        rst = 1'b0;
        pulse = 1'b0;
        enable = 1'b0;
        check("midrst_led", 32'(led), 32'h00);
        check("midrst_dir", 32'(dir), 32'd0);
        check("midrst_at_end", 32'(at_end), 32'd0);
        check("midrst_step", 32'(step), 32'd0);
        pnone(2);
        check("midrst_still_idle", 32'(led), 32'h00);

        // Restart, then lower speed mid-count
        push(0, 8'h01, 1'b0, 1'b1, "restart");
        enable = 1'b1;
        tick();
        pnone(2);
        speed = 4'd0;
        pstep(8'h02, 1'b0, 1'b0, "speed_drop");
        pstep(8'h04, 1'b0, 1'b0, "up2_04");
        pstep(8'h08, 1'b0, 1'b0, "up2_08");
        pstep(8'h10, 1'b0, 1'b0, "up2_10");
        drain("restart");

        // Park from 0x10 while moving up
        enable = 1'b0;
        tick();
        check("park_dir", 32'(dir), 32'd1);
        check("park_led", 32'(led), 32'h10);
        check("park_at_end", 32'(at_end), 32'd0);
        pstep(8'h08, 1'b1, 1'b0, "park_08");
        pstep(8'h04, 1'b1, 1'b0, "park_04");
        pstep(8'h02, 1'b1, 1'b0, "park_02");
        pstep(8'h01, 1'b1, 1'b0, "park_01");
        pstep(8'h00, 1'b0, 1'b0, "park_idle");
        pnone(2);
        check("parked_led", 32'(led), 32'h00);
        drain("park");

        // Resume from park at 0x04
        push(0, 8'h01, 1'b0, 1'b1, "start3");
        enable = 1'b1;
        tick();
        pstep(8'h02, 1'b0, 1'b0, "up3_02");
        pstep(8'h04, 1'b0, 1'b0, "up3_04");
        pstep(8'h08, 1'b0, 1'b0, "up3_08");
        enable = 1'b0;
        tick();
        pstep(8'h04, 1'b1, 1'b0, "park2_04");
        enable = 1'b1;
        tick();
        check("resume_dir", 32'(dir), 32'd1);
        check("resume_led", 32'(led), 32'h04);
        check("resume_step", 32'(step), 32'd0);
        pstep(8'h02, 1'b1, 1'b0, "resume_02");
        pstep(8'h01, 1'b1, 1'b1, "resume_01");
        pstep(8'h01, 1'b1, 1'b1, "resume_dwell");
        pstep(8'h02, 1'b0, 1'b0, "resume_rise_02");
        pstep(8'h04, 1'b0, 1'b0, "resume_rise_04");
        drain("resume");

        // END_HOLD = 0 instance, back-to-back pulses
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        push(1, 8'h01, 1'b0, 1'b1, "h0_start");
        enable0 = 1'b1;
        tick();
        push(1, 8'h02, 1'b0, 1'b0, "h0_02"); do_pulse(0);
        push(1, 8'h04, 1'b0, 1'b0, "h0_04"); do_pulse(0);
        push(1, 8'h08, 1'b0, 1'b0, "h0_08"); do_pulse(0);
        push(1, 8'h10, 1'b0, 1'b0, "h0_10"); do_pulse(0);
        push(1, 8'h20, 1'b0, 1'b0, "h0_20"); do_pulse(0);
        push(1, 8'h40, 1'b0, 1'b0, "h0_40"); do_pulse(0);
        push(1, 8'h80, 1'b0, 1'b1, "h0_top"); do_pulse(0);
        push(1, 8'h40, 1'b1, 1'b0, "h0_no_dwell"); do_pulse(0);
        push(1, 8'h20, 1'b1, 1'b0, "h0_20_down"); do_pulse(0);
        drain("hold0");
        check("hold0_other_idle", 32'(led), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
